// File: rtl/pulse_stretcher_if.sv
// pulse_stretcher_if: tick/clear requests in, stretched level and queue status out.
interface pulse_stretcher_if #(
    parameter int PEND_W = 3
);
    logic              tick;
    logic              clr_ovf;
    logic              level;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (output tick, output clr_ovf, input level, input busy, input pending, input overflow);
    modport slave  (input tick, input clr_ovf, output level, output busy, output pending, output overflow);
endinterface

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns tick strobes into fixed-width pulses with a guaranteed low gap.
// PULSE_STRETCH_RETRIGGER_EN: ticks during HIGH extend the pulse instead of queueing.
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 2,
    parameter int PEND_W      = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    pulse_stretcher_if.slave    bus
);
    localparam int MAXC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HC = CW'(HIGH_CYCLES);
    localparam logic [CW-1:0] LC = CW'(LOW_CYCLES);
    localparam logic [PEND_W-1:0] PMAX = '1;

    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [PEND_W-1:0] pend_nx;
    logic              enq, deq, drop, last, ovf_nx;

    assign last = cnt == CW'(1);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        enq      = 1'b0;
        deq      = 1'b0;
        case (state)
            IDLE: begin
                state_nx = bus.tick ? HIGH : IDLE;
                cnt_nx   = bus.tick ? HC : cnt;
            end
            HIGH: begin
                state_nx = last ? GAP : HIGH;
                cnt_nx   = last ? LC : cnt - CW'(1);
`ifdef PULSE_STRETCH_RETRIGGER_EN
                if (bus.tick) begin
                    state_nx = HIGH;
                    cnt_nx   = HC;
                end
`else
                enq = bus.tick;
`endif
            end
            GAP: begin
                if (!last) begin
                    cnt_nx = cnt - CW'(1);
                    enq    = bus.tick;
                end else if (bus.pending != '0) begin
                    // Dequeue and re-queue the same-cycle tick: net pending unchanged.
                    deq      = 1'b1;
                    enq      = bus.tick;
                    state_nx = HIGH;
                    cnt_nx   = HC;
                end else begin
                    state_nx = bus.tick ? HIGH : IDLE;
                    cnt_nx   = bus.tick ? HC : cnt;
                end
            end
            default: state_nx = IDLE;
        endcase
        drop    = enq && !deq && bus.pending == PMAX;
        pend_nx = (enq && !deq && !drop) ? bus.pending + PEND_W'(1) :
                  (deq && !enq) ? bus.pending - PEND_W'(1) : bus.pending;
        ovf_nx  = drop || (bus.overflow && !bus.clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.level    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.pending  <= '0;
            bus.overflow <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            bus.level    <= state_nx == HIGH;
            bus.busy     <= state_nx != IDLE;
            bus.pending  <= pend_nx;
            bus.overflow <= ovf_nx;
        end
    end
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: directed test-plan scenarios plus random ticks against a cycle-count reference model.
module tb_pulse_stretcher;
    localparam int H = 4;
    localparam int L = 2;
    localparam int PMAX = 7;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   m_hrem = 0, m_grem = 0, m_pend = 0, m_ovf = 0;

    pulse_stretcher_if #(.PEND_W(3)) bus ();
    pulse_stretcher dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Remaining-cycle bookkeeping: hrem high cycles left (incl. current), grem gap cycles left.
    task automatic model(input logic t, input logic c, input logic r);
        int q = 0, d = 0, np;
        bit set = 0;
        if (!r) begin
            m_hrem = 0; m_grem = 0; m_pend = 0; m_ovf = 0;
            return;
        end
        if (m_hrem > 0) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
            if (t) m_hrem = H + 1;
`else
            q = int'(t);
`endif
            m_hrem--;
            if (m_hrem == 0) m_grem = L;
        end else if (m_grem > 1) begin
            q = int'(t);
            m_grem--;
        end else if (m_grem == 1) begin
            m_grem = 0;
            if (m_pend > 0) begin
                d = 1; q = int'(t); m_hrem = H;
            end else if (t) m_hrem = H;
        end else if (t) m_hrem = H;
        np = m_pend + q - d;
        if (np > PMAX) begin
            np = PMAX; set = 1;
        end
        m_pend = np;
        m_ovf = set ? 1 : (c ? 0 : m_ovf);
    endtask

    task automatic step(input logic t, input logic c, input logic r);
        bus.tick = t; bus.clr_ovf = c; rst_n = r;
        @(posedge clk);
        model(t, c, r);
        #1;
        chk("level", int'(bus.level), int'(m_hrem > 0));
        chk("busy", int'(bus.busy), int'(m_hrem > 0 || m_grem > 0));
        chk("pending", int'(bus.pending), m_pend);
        chk("overflow", int'(bus.overflow), m_ovf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.tick = 1'b0; bus.clr_ovf = 1'b0; rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("rst_level", int'(bus.level), 0);
        chk("rst_pending", int'(bus.pending), 0);
        idle(3);
        // single tick: high 4 cycles, gap 2, then idle
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            chk("single_level", int'(bus.level), int'(i < H));
            chk("single_busy", int'(bus.busy), int'(i < H + L));
            step(1'b0, 1'b0, 1'b1);
        end
        idle(3);
        // ticks at 10 and 13: queued second pulse, or extended pulse when retriggering
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int cyc = 14; cyc <= 21; cyc++) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
            chk("pair_level", int'(bus.level), int'(cyc <= 17));
            chk("pair_pending", int'(bus.pending), 0);
`else
            chk("pair_level", int'(bus.level), int'(cyc == 14 || (cyc >= 17 && cyc <= 20)));
            chk("pair_pending", int'(bus.pending), int'(cyc <= 16));
`endif
            step(1'b0, 1'b0, 1'b1);
        end
        idle(6);
        // tick on the last gap cycle with nothing queued: back-to-back pulse
        step(1'b1, 1'b0, 1'b1);
        idle(5);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < H; i++) begin
            chk("lastgap_level", int'(bus.level), 1);
            chk("lastgap_pending", int'(bus.pending), 0);
            step(1'b0, 1'b0, 1'b1);
        end
        idle(4);
        // tick held 16 cycles: saturation and overflow, then set-vs-clear
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1);
`ifndef PULSE_STRETCH_RETRIGGER_EN
        chk("sat_pending", int'(bus.pending), PMAX);
        chk("sat_overflow", int'(bus.overflow), 1);
        step(1'b1, 1'b1, 1'b1);
        chk("set_wins", int'(bus.overflow), 1);
`endif
        step(1'b0, 1'b1, 1'b1);
        chk("clr_ovf", int'(bus.overflow), 0);
        idle(60);
        // reset mid-pulse discards the queue
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("rstmid_level", int'(bus.level), 0);
        chk("rstmid_busy", int'(bus.busy), 0);
        chk("rstmid_pending", int'(bus.pending), 0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("rstmid_quiet", int'(bus.level), 0);
        end
        // random ticks, clears and occasional resets
        for (int i = 0; i < 3000; i++)
            step(logic'($urandom_range(99) < 45), logic'($urandom_range(99) < 6),
                 logic'($urandom_range(199) != 0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle `tick` strobes into clean level pulses of fixed high width, separated by a guaranteed low gap. This is the inverse of the push-button edge detector: it turns ticks from control logic into levels that drive LEDs, ADC start/convert lines, or a downstream edge detector. Ticks that arrive while a pulse is in progress are queued in a saturating counter, so none are silently lost.

## Interface
- `HIGH_CYCLES`, default 4: level-high width in `clk` cycles; must be ≥1.
- `LOW_CYCLES`, default 2: forced low gap after every pulse; must be ≥1.
- `PEND_W`, default 3: width of the pending-tick counter; it saturates at 2^PEND_W−1.
- `clk`  in  1  system clock from the PLL.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `tick`  in  1  request strobe, sampled on every rising `clk` edge; a high level on N cycles counts as N ticks.
- `clr_ovf`  in  1  clears `overflow`.
- `level`  out  1  stretched output pulse, registered.
- `busy`  out  1  high when the state is not IDLE, registered.
- `pending`  out  PEND_W  number of queued ticks, registered.
- `overflow`  out  1  sticky flag: a tick arrived while `pending` was saturated.

## Operation
- FSM states: IDLE, HIGH, GAP. A down-counter sized for max(HIGH_CYCLES, LOW_CYCLES) is loaded on each state entry.
- Outputs: `level` = 1 only in HIGH. `busy` = 1 in HIGH and GAP.
- IDLE, `tick`=1: go to HIGH and load HIGH_CYCLES.
- HIGH: stay exactly HIGH_CYCLES cycles, then go to GAP and load LOW_CYCLES.
- HIGH, `tick`=1: increment `pending` (non-retrigger build).
- GAP: stay exactly LOW_CYCLES cycles. On the last GAP cycle:
  - if `pending`>0: decrement `pending` and go to HIGH;
  - else if `tick`=1: go to HIGH, `pending` unchanged;
  - else: go to IDLE.
- GAP, `tick`=1 on any cycle other than the last: increment `pending`.
- Same-cycle tick and dequeue on the last GAP cycle with `pending`>0: the tick is queued and one entry is dequeued, so `pending` is unchanged.
- Saturation: a tick with `pending` = 2^PEND_W−1 is dropped and sets `overflow`. `pending` never wraps.
- `overflow` is cleared by `clr_ovf`=1. If a set and a clear occur in the same cycle, set wins.
- Reset values: state IDLE, `level`=0, `busy`=0, `pending`=0, `overflow`=0.
- Reset asserted mid-pulse: `level` drops on the next edge, the queue is discarded, and there is no residual pulse after release.

## Timing
- Reference timing: tick sampled at cycle T from IDLE.
  - `level`=1 in cycles T+1 … T+HIGH_CYCLES.
  - `level`=0 in cycles T+HIGH_CYCLES+1 … T+HIGH_CYCLES+LOW_CYCLES.
  - Earliest next high cycle: T+HIGH_CYCLES+LOW_CYCLES+1.
- Latency from tick to `level` rise: 1 cycle.
- `pending` and `overflow` update 1 cycle after the causing tick.
- A queued pulse starts with no idle cycle between its GAP and the next HIGH.
- `busy` falls in the same cycle the FSM enters IDLE.

## Configuration
- Macro: `PULSE_STRETCH_RETRIGGER_EN`.
- Defined: a tick during HIGH reloads the counter with HIGH_CYCLES, extending the current pulse. `pending` is not incremented. Ticks during GAP still queue.
- Undefined: ticks during HIGH queue in `pending` as described in Operation.

## Test plan
All scenarios use default parameters.
- Single tick at cycle 10:
  - `level`=1 in cycles 11–14, 0 in 15–16.
  - `busy`=1 in 11–16, IDLE at 17.
- Ticks at 10 and 12:
  - Pulses in 11–14 and 17–20.
  - `pending`=1 in 13–16, 0 from 17.
- `tick` held high in cycles 10–25:
  - `pending` saturates at 7, never exceeds 7.
  - `overflow`=1 once a tick arrives at saturation.
  - `clr_ovf` pulse with `tick` low: `overflow`=0 next cycle.
  - `clr_ovf` and a saturating tick in the same cycle: `overflow` stays 1.
- Tick at 10 and tick at 16 (last GAP cycle, `pending`=0):
  - `level`=1 in 11–14 and 17–20.
  - `pending` stays 0.
- Reset mid-pulse:
  - Ticks at 10 and 11; `rst_n`=0 in cycle 12.
  - Cycle 13: `level`=0, `pending`=0, `busy`=0.
  - No pulse after `rst_n` returns to 1.
- With `PULSE_STRETCH_RETRIGGER_EN` defined, ticks at 10 and 13:
  - `level`=1 in 11–17, 0 in 18–19.
  - `pending` stays 0.
  - Without the macro, the same stimulus gives pulses in 11–14 and 17–20.
